// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide unit with architectural HI/LO.
// Shift-add multiply and restoring divide, plus MTHI/MTLO writes.
//
// Parameters:
//   WIDTH  operand and HI/LO width (even, >= 4)
//   CNTW   iteration counter width (derived)
// Ports:
//   clk, reset      clock, async active-high reset
//   start, op       launch; 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b            rs / rt operands
//   hi_we, lo_we    MTHI / MTLO strobes, data on wd
//   busy, done      operation in flight / one-cycle result pulse
//   dz              last divide had b == 0 (sticky until next start)
//   hi, lo          architectural HI / LO
// Build option:
//   MDU_EARLY_OUT_EN  multiplies stop once the multiplier is exhausted
module mdu_seq #(
   parameter int WIDTH = 32,
   parameter int CNTW  = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wd,
   output logic             busy,
   output logic             done,
   output logic             dz,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int W2 = 2*WIDTH;

   typedef enum logic [1:0] {
      S_IDLE, S_CALC, S_SIGN, S_DONE
   } state_e;

   state_e state_q, state_d;

   logic             div_q, div_d;
   logic             neg_a_q, neg_a_d;
   logic             neg_b_q, neg_b_d;
   logic             bz_q, bz_d;
   logic             dz_q, dz_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic [W2-1:0]    x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   rem_sh, diff;
   logic [W2-1:0]    prod;
   logic [WIDTH-1:0] quo, rem, raw_a;
   logic             accept, last;

   // Magnitudes for signed ops; -2^(W-1) maps onto itself,
   // which reads correctly as an unsigned magnitude.
   assign mag_a = (op[0] && a[WIDTH-1]) ? -a : a;
   assign mag_b = (op[0] && b[WIDTH-1]) ? -b : b;

   assign accept = start &&
                   (state_q == S_IDLE || state_q == S_DONE);

   // Divide: acc = {rem, quot}; x low half = divisor,
   // x high half keeps |a| for the divide-by-zero result.
   assign rem_sh = acc_q[W2-1:WIDTH-1];
   assign diff   = rem_sh - {1'b0, x_q[WIDTH-1:0]};

   assign prod  = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
   assign quo   = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0]
                                      : acc_q[WIDTH-1:0];
   assign rem   = neg_a_q ? -acc_q[W2-1:WIDTH]
                          : acc_q[W2-1:WIDTH];
   assign raw_a = neg_a_q ? -x_q[W2-1:WIDTH]
                          : x_q[W2-1:WIDTH];

`ifdef MDU_EARLY_OUT_EN
   assign last = (cnt_q == CNTW'(WIDTH-1)) ||
                 (!div_q && (y_q[WIDTH-1:1] == '0));
`else
   assign last = (cnt_q == CNTW'(WIDTH-1));
`endif

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      neg_a_d = neg_a_q;
      neg_b_d = neg_b_q;
      bz_d    = bz_q;
      dz_d    = dz_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      x_d     = x_q;
      y_d     = y_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (hi_we) hi_d = wd;
            if (lo_we) lo_d = wd;
            if (accept) begin
               state_d = S_CALC;
               div_d   = op[1];
               neg_a_d = op[0] & a[WIDTH-1];
               neg_b_d = op[0] & b[WIDTH-1];
               bz_d    = (b == '0);
               dz_d    = 1'b0;
               cnt_d   = '0;
               if (op[1]) begin
                  acc_d = {{WIDTH{1'b0}}, mag_a};
                  x_d   = {mag_a, mag_b};
                  y_d   = '0;
               end else begin
                  acc_d = '0;
                  x_d   = {{WIDTH{1'b0}}, mag_a};
                  y_d   = mag_b;
               end
            end
         end
         S_CALC: begin
            cnt_d = cnt_q + 1'b1;
            if (div_q) begin
               if (!diff[WIDTH])
                  acc_d = {diff[WIDTH-1:0],
                           acc_q[WIDTH-2:0], 1'b1};
               else
                  acc_d = {rem_sh[WIDTH-1:0],
                           acc_q[WIDTH-2:0], 1'b0};
            end else begin
               if (y_q[0]) acc_d = acc_q + x_q;
               x_d = x_q << 1;
               y_d = y_q >> 1;
            end
            if (last) state_d = S_SIGN;
         end
         S_SIGN: begin
            state_d = S_DONE;
            if (!div_q) begin
               {hi_d, lo_d} = prod;
            end else if (bz_q) begin
               lo_d = '1;
               hi_d = raw_a;
               dz_d = 1'b1;
            end else begin
               lo_d = quo;
               hi_d = rem;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         div_q   <= 1'b0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         bz_q    <= 1'b0;
         dz_q    <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         neg_a_q <= neg_a_d;
         neg_b_q <= neg_b_d;
         bz_q    <= bz_d;
         dz_q    <= dz_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         x_q     <= x_d;
         y_q     <= y_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = (state_q == S_CALC) || (state_q == S_SIGN);
   assign done = (state_q == S_DONE);
   assign dz   = dz_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: randomized + directed bench for mdu_seq (WIDTH=32).
// Driver queues expected results; a monitor checks each done pulse.
module tb_mdu_seq;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  a, b, wd;
   logic          hi_we, lo_we;
   logic          busy, done, dz;
   logic [W-1:0]  hi, lo;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           lat;
      int           t0;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   ndone = 0;

   mdu_seq #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
      .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: plain 64-bit arithmetic on the operands.
   function automatic exp_t model(input logic [1:0] o,
                                  input logic [W-1:0] x,
                                  input logic [W-1:0] y,
                                  input int t0);
      exp_t e;
      longint sx, sy, q, r, p;
      longint unsigned up;
      logic [W-1:0] my;
      int k;
      e.dz  = 1'b0;
      e.t0  = t0;
      e.lat = W + 2;
      e.hi  = '0;
      e.lo  = '0;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         2'b00: begin
            up = 64'(x) * 64'(y);
            {e.hi, e.lo} = up;
         end
         2'b01: begin
            p = sx * sy;
            {e.hi, e.lo} = p;
         end
         2'b10: begin
            if (y == 0) begin
               e.lo = '1; e.hi = x; e.dz = 1'b1;
            end else begin
               e.lo = x / y; e.hi = x % y;
            end
         end
         default: begin
            if (y == 0) begin
               e.lo = '1; e.hi = x; e.dz = 1'b1;
            end else begin
               q = sx / sy; r = sx % sy;
               e.lo = q[W-1:0]; e.hi = r[W-1:0];
            end
         end
      endcase
`ifdef MDU_EARLY_OUT_EN
      if (!o[1]) begin
         my = (o[0] && y[W-1]) ? -y : y;
         k = 1;
         for (int i = 0; i < W; i++)
            if (my[i]) k = i + 1;
         e.lat = k + 2;
      end
`else
      my = '0;
      k  = 0;
`endif
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && done) begin
            ndone++;
            if (sb.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_done: got done=1 expected 0");
            end else begin
               e = sb.pop_front();
               chk("res_hi", 64'(hi), 64'(e.hi));
               chk("res_lo", 64'(lo), 64'(e.lo));
               chk("res_dz", 64'(dz), 64'(e.dz));
               chk("latency", 64'(cyc - e.t0), 64'(e.lat));
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         tests++; fails++;
         $display("FAIL wait_idle: got busy=1 expected 0");
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         tests++; fails++;
         $display("FAIL wait_done: got done=0 expected 1");
      end
   endtask

   // Issue one op; returns at the negedge after acceptance.
   task automatic issue(input logic [1:0] o,
                        input logic [W-1:0] x,
                        input logic [W-1:0] y);
      wait_idle();
      start = 1'b1; op = o; a = x; b = y;
      sb.push_back(model(o, x, y, cyc));
      @(negedge clk);
      start = 1'b0;
      op = 2'($urandom); a = $urandom; b = $urandom;
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("dz_cleared", 64'(dz), 64'd0);
   endtask

   function automatic logic [W-1:0] rval();
      case ($urandom_range(0, 6))
         0: return '0;
         1: return 32'd1;
         2: return '1;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int n0;
      reset = 1'b1; start = 1'b0; op = 2'b00;
      a = '0; b = '0; wd = '0; hi_we = 1'b0; lo_we = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_dz", 64'(dz), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // MTHI / MTLO in IDLE
      hi_we = 1'b1; wd = 32'hA5A5_A5A5;
      @(negedge clk);
      hi_we = 1'b0;
      chk("mthi_hi", 64'(hi), 64'hA5A5_A5A5);
      chk("mthi_lo", 64'(lo), 64'd0);
      lo_we = 1'b1; wd = 32'h5A5A_5A5A;
      @(negedge clk);
      lo_we = 1'b0;
      chk("mtlo_lo", 64'(lo), 64'h5A5A_5A5A);
      hi_we = 1'b1; lo_we = 1'b1; wd = 32'hC3C3_C3C3;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      chk("mtboth_hi", 64'(hi), 64'hC3C3_C3C3);
      chk("mtboth_lo", 64'(lo), 64'hC3C3_C3C3);

      // Writes while busy are dropped
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      hi_we = 1'b1; lo_we = 1'b1; wd = 32'hDEAD_BEEF;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      chk("busy_we_hi", 64'(hi), 64'hC3C3_C3C3);
      chk("busy_we_lo", 64'(lo), 64'hC3C3_C3C3);

      // MTLO in DONE is honoured
      wait_done();
      lo_we = 1'b1; wd = 32'h1357_2468;
      @(negedge clk);
      lo_we = 1'b0;
      chk("done_mtlo", 64'(lo), 64'h1357_2468);
      chk("done_to_idle", 64'(done), 64'd0);

      // Directed ops, issued back-to-back where possible
      issue(2'b01, -32'sd3, 32'd7);
      issue(2'b11, -32'sd7, 32'd2);
      issue(2'b10, 32'd100, 32'd7);
      issue(2'b10, 32'h1234, 32'd0);
      issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(2'b11, 32'd5, 32'd0);
      issue(2'b00, 32'd3, 32'd5);
      issue(2'b01, 32'h8000_0000, 32'h8000_0000);

      // Start while busy must be ignored
      issue(2'b00, 32'd1234, 32'd5678);
      repeat (3) @(negedge clk);
      start = 1'b1; op = 2'b11; a = 32'd99; b = 32'd3;
      @(negedge clk);
      start = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 40; i++)
         issue(2'($urandom), rval(), rval());

      // Reset mid-operation
      issue(2'b00, 32'd12345, 32'd678);
      repeat (8) @(negedge clk);
      reset = 1'b1;
      sb.delete();
      #1;
      chk("midrst_hi", 64'(hi), 64'd0);
      chk("midrst_lo", 64'(lo), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      n0 = ndone;
      repeat (40) @(negedge clk);
      chk("midrst_no_done", 64'(ndone), 64'(n0));
      chk("midrst_idle", 64'(busy), 64'd0);

      // A clean op after reset
      issue(2'b11, 32'hFFFF_FF9C, 32'd7);
      for (int i = 0; i < 200 && sb.size() != 0; i++)
         @(negedge clk);
      chk("drain", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
